// File: rtl/pattern_detector_pkg.sv
// Shared definitions for the pattern detector: FSM encoding, pattern geometry.
// Pure declarations, no logic.
package pattern_detector_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int PAT_LEN = 4;
    localparam int IDX_W   = 2;
    localparam int REP_W   = 4;

    // Pattern byte index advances modulo the pattern length.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(PAT_LEN - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/pattern_detector_if.sv
// Byte-strobe/comparator and status bundle between the detector and its user.
// master drives strobe/compare/clear; slave (the detector) drives status.
interface pattern_detector_if #(
    parameter int CNT_W = 8
);
    import pattern_detector_pkg::*;

    logic               byte_stb;
    logic               true_byte;
    logic               clear;
    logic [IDX_W-1:0]   byte_num;
    logic [REP_W-1:0]   rep_count;
    logic               pattern_found;
    logic               locked;
    logic [CNT_W-1:0]   mismatch_cnt;
    logic               overrun;

    modport master (
        output byte_stb, true_byte, clear,
        input  byte_num, rep_count, pattern_found, locked, mismatch_cnt, overrun
    );

    modport slave (
        input  byte_stb, true_byte, clear,
        output byte_num, rep_count, pattern_found, locked, mismatch_cnt, overrun
    );

endinterface

// File: rtl/pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; 1-cycle update latency.
// No backpressure: inc is ignored once the count is all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pattern_detector.sv
// Frame-pattern search: counts consecutive 4-byte matches and locks after N_REPEAT.
// Lock pulse 2 cycles after the final byte strobe; no backpressure, closely spaced strobes flag overrun.
module pattern_detector
    import pattern_detector_pkg::*;
#(
    parameter int N_REPEAT = 5,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    pattern_detector_if.slave bus
);

    localparam logic [REP_W-1:0] REP_LOCK = REP_W'(N_REPEAT);

    state_t             state;
    logic               cmp_valid;
    logic [IDX_W-1:0]   byte_num;
    logic [REP_W-1:0]   rep_count;
    logic               pattern_found;
    logic               locked;
    logic               overrun;
    logic [CNT_W-1:0]   mismatch_cnt;

    logic               miss;
    logic [REP_W-1:0]   rep_next;
    logic               last_byte;

    assign miss      = (state == SEARCH) && cmp_valid && !bus.true_byte && !bus.clear;
    assign rep_next  = rep_count + 1'b1;
    assign last_byte = (byte_num == IDX_W'(PAT_LEN - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= SEARCH;
            cmp_valid     <= 1'b0;
            byte_num      <= '0;
            rep_count     <= '0;
            pattern_found <= 1'b0;
            locked        <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            cmp_valid     <= bus.byte_stb;
            pattern_found <= 1'b0;
            if (bus.clear) begin
                state     <= SEARCH;
                byte_num  <= '0;
                rep_count <= '0;
                locked    <= 1'b0;
                overrun   <= 1'b0;
            end else begin
                // A strobe while the previous one is still being compared is a spacing violation.
                if (bus.byte_stb && cmp_valid) begin
                    overrun <= 1'b1;
                end
                case (state)
                    SEARCH: begin
                        if (cmp_valid) begin
                            if (bus.true_byte) begin
                                byte_num <= next_idx(byte_num);
                                if (last_byte) begin
                                    rep_count <= rep_next;
                                    if (rep_next == REP_LOCK) begin
                                        state         <= LOCKED;
                                        locked        <= 1'b1;
                                        pattern_found <= 1'b1;
                                    end
                                end
                            end else begin
                                byte_num  <= '0;
                                rep_count <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        byte_num  <= '0;
                        rep_count <= REP_LOCK;
                    end
                    default: begin
                        state <= SEARCH;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_mismatch_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss),
        .clr   (bus.clear),
        .count (mismatch_cnt)
    );

    assign bus.byte_num      = byte_num;
    assign bus.rep_count     = rep_count;
    assign bus.pattern_found = pattern_found;
    assign bus.locked        = locked;
    assign bus.mismatch_cnt  = mismatch_cnt;
    assign bus.overrun       = overrun;

endmodule
